// File: rtl/apb_req_master.sv
// apb_req_master: turns a valid/ready request into one APB4 SETUP->ACCESS
// transfer and returns the result on a valid/ready response channel.
// A bounded wait in ACCESS turns a hung slave into an error response.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; APB address/control keep last values
// SETUP  | psel high, penable low; wait counter cleared
// ACCESS | psel and penable high; waiting for pready or timeout
// RESP   | response held on rsp_* until rsp_ready_i
module apb_req_master #(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int STRB_WIDTH     = (DATA_WIDTH + 7) / 8
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [2:0]            pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    // Counter must hold TIMEOUT_CYCLES itself; at least one bit so a
    // disabled timeout still has a legal vector.
    localparam int CNT_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Abort fires on the ACCESS cycle whose count reaches the threshold, so
    // exactly TIMEOUT_CYCLES ACCESS cycles are spent before giving up.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign pprot_o     = 3'b000;

    // State register
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-only handshake/APB strobes
    always_comb begin
        next_state  = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                psel_o     = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // APB address/data flops, response capture and wait counter
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            paddr_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        paddr_o  <= req_addr_i;
                        pwrite_o <= req_write_i;
                        pwdata_o <= req_write_i ? req_wdata_i : '0;
                        pstrb_o  <= req_write_i ? req_strb_i : '0;
                    end
                end
                SETUP: begin
                    cnt <= '0;
                end
                ACCESS: begin
                    // pready wins over a coincident timeout
                    if (pready_i) begin
                        rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                        rsp_err_o     <= pslverr_i;
                        rsp_timeout_o <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata_o   <= '0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: scoreboard of expected responses, APB slave
// driven from the stimulus tasks, protocol monitor on the APB strobes.
module tb_apb_req_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          preset_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic          req_write_i;
    logic [DW-1:0] req_wdata_i;
    logic [SW-1:0] req_strb_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic [AW-1:0] paddr_o;
    logic [2:0]    pprot_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic          pready_i;
    logic [DW-1:0] prdata_i;
    logic          pslverr_i;

    apb_req_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk_i(clk), .preset_i(preset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o),
        .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .pstrb_o(pstrb_o), .pready_i(pready_i), .prdata_i(prdata_i),
        .pslverr_i(pslverr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   prot_viol = 0;

    // Protocol monitor: penable needs psel, and never in the first psel cycle
    logic prev_psel = 1'b0;
    always @(negedge clk) begin
        if (penable_o && !psel_o) begin
            prot_viol++;
            $display("FAIL protocol: penable=1 with psel=0 at %0t", $time);
        end
        if (penable_o && psel_o && !prev_psel) begin
            prot_viol++;
            $display("FAIL protocol: penable=1 in first psel cycle at %0t", $time);
        end
        prev_psel = psel_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for one transfer: how many ACCESS cycles and what response
    function automatic exp_t model(input logic wr, input int waits,
                                   input logic [DW-1:0] rd, input logic se);
        exp_t e;
        if (waits >= TO) begin
            e.rdata = '0; e.err = 1'b1; e.to = 1'b1; e.acc = TO;
        end else begin
            e.rdata = wr ? '0 : rd; e.err = se; e.to = 1'b0; e.acc = waits + 1;
        end
        return e;
    endfunction

    // Drives one request and plays the slave: pready rises on ACCESS cycle 'waits'
    task automatic run_xfer(input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wd, input logic [SW-1:0] st,
                            input int waits, input logic [DW-1:0] rd,
                            input logic se, output int acc,
                            output bit setup_ok, output bit hold_ok);
        logic [DW-1:0] ewd;
        logic [SW-1:0] est;
        ewd = wr ? wd : '0;
        est = wr ? st : '0;
        q.push_back(model(wr, waits, rd, se));
        req_valid_i = 1'b1; req_addr_i = addr; req_write_i = wr;
        req_wdata_i = wd;   req_strb_i = st;
        setup_ok = (req_ready_o === 1'b1);
        tick();
        req_valid_i = 1'b0;
        req_wdata_i = $urandom; req_strb_i = 4'($urandom);
        setup_ok = setup_ok && psel_o === 1'b1 && penable_o === 1'b0 &&
                   req_ready_o === 1'b0 && paddr_o === addr &&
                   pwrite_o === wr && pwdata_o === ewd && pstrb_o === est;
        tick();
        acc = 0;
        hold_ok = 1'b1;
        while (psel_o && penable_o && acc < 40) begin
            if (paddr_o !== addr || pwrite_o !== wr || pwdata_o !== ewd ||
                pstrb_o !== est || req_ready_o !== 1'b0)
                hold_ok = 1'b0;
            pready_i = (acc == waits); prdata_i = rd; pslverr_i = se;
            tick();
            acc++;
        end
        pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    endtask

    // Waits for a response, holds rsp_ready low 'hold' cycles, then consumes it
    task automatic get_rsp(input int hold, output logic [DW-1:0] rd,
                           output logic err, output logic to,
                           output bit got, output bit stable);
        int n;
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        got = (rsp_valid_o === 1'b1);
        rd = rsp_rdata_o; err = rsp_err_o; to = rsp_timeout_o;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== rd || rsp_err_o !== err ||
                rsp_timeout_o !== to || req_ready_o !== 1'b0 || psel_o !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        preset_i = 1'b1;
        tick(); tick();
        preset_i = 1'b0;
        total++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || psel_o !== 1'b0 ||
            penable_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy=%b rv=%b psel=%b pen=%b want 1 0 0 0",
                     req_ready_o, rsp_valid_o, psel_o, penable_o);
        end
        total++;
        if (paddr_o !== '0 || pwdata_o !== '0 || pstrb_o !== '0 ||
            pwrite_o !== 1'b0 || pprot_o !== 3'b000) begin
            bad++;
            $display("FAIL reset_apb: got addr=%h wd=%h st=%h wr=%b prot=%b want all 0",
                     paddr_o, pwdata_o, pstrb_o, pwrite_o, pprot_o);
        end
        total++;
        if (rsp_rdata_o !== '0 || rsp_err_o !== 1'b0 || rsp_timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp: got rd=%h err=%b to=%b want 0 0 0",
                     rsp_rdata_o, rsp_err_o, rsp_timeout_o);
        end
    endtask

    task automatic test_zero_wait_write();
        int acc; bit s_ok, h_ok, got, stb; logic [DW-1:0] rd; logic err, to;
        exp_t e;
        run_xfer(32'h0003_0000, 1'b1, 32'h0000_5A5A, 4'hF, 0, 32'hDEAD_BEEF, 1'b0,
                 acc, s_ok, h_ok);
        total++;
        if (!s_ok) begin
            bad++;
            $display("FAIL zw_setup: got setup_ok=%b want 1", s_ok);
        end
        total++;
        if (rsp_valid_o !== 1'b1 || acc != 1) begin
            bad++;
            $display("FAIL zw_latency: got rsp_valid=%b acc=%0d at cycle 3, want 1 and 1",
                     rsp_valid_o, acc);
        end
        get_rsp(0, rd, err, to, got, stb);
        e = q.pop_front();
        total++;
        if (!got || rd !== e.rdata || err !== e.err || to !== e.to) begin
            bad++;
            $display("FAIL zw_rsp: got v=%b rd=%h err=%b to=%b want 1 %h %b %b",
                     got, rd, err, to, e.rdata, e.err, e.to);
        end
    endtask

    task automatic test_read_waits();
        int acc; bit s_ok, h_ok, got, stb; logic [DW-1:0] rd; logic err, to;
        exp_t e;
        run_xfer(32'h0000_0040, 1'b0, 32'hFFFF_FFFF, 4'hF, 3, 32'h0000_1234, 1'b0,
                 acc, s_ok, h_ok);
        e = q.pop_front();
        total++;
        if (!s_ok || !h_ok || acc != e.acc) begin
            bad++;
            $display("FAIL rd_wait_apb: got setup_ok=%b hold_ok=%b acc=%0d want 1 1 %0d",
                     s_ok, h_ok, acc, e.acc);
        end
        get_rsp(0, rd, err, to, got, stb);
        total++;
        if (!got || rd !== e.rdata || err !== e.err || to !== e.to) begin
            bad++;
            $display("FAIL rd_wait_rsp: got v=%b rd=%h err=%b to=%b want 1 %h %b %b",
                     got, rd, err, to, e.rdata, e.err, e.to);
        end
    endtask

    task automatic test_slverr();
        int acc; bit s_ok, h_ok, got, stb; logic [DW-1:0] rd; logic err, to;
        exp_t e;
        run_xfer(32'h0002_FF00, 1'b1, 32'hCAFE_0001, 4'h3, 0, 32'h0, 1'b1,
                 acc, s_ok, h_ok);
        get_rsp(0, rd, err, to, got, stb);
        e = q.pop_front();
        total++;
        if (!got || rd !== e.rdata || err !== 1'b1 || to !== 1'b0 || acc != e.acc) begin
            bad++;
            $display("FAIL slverr: got v=%b rd=%h err=%b to=%b acc=%0d want 1 %h 1 0 %0d",
                     got, rd, err, to, acc, e.rdata, e.acc);
        end
    endtask

    task automatic test_timeout();
        int acc; bit s_ok, h_ok, got, stb; logic [DW-1:0] rd; logic err, to;
        exp_t e;
        run_xfer(32'h0000_0100, 1'b0, 32'h0, 4'h0, 1000, 32'h5555_AAAA, 1'b0,
                 acc, s_ok, h_ok);
        e = q.pop_front();
        total++;
        if (acc != TO || psel_o !== 1'b0 || penable_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_len: got acc=%0d psel=%b pen=%b want %0d 0 0",
                     acc, psel_o, penable_o, TO);
        end
        get_rsp(0, rd, err, to, got, stb);
        total++;
        if (!got || rd !== e.rdata || err !== 1'b1 || to !== 1'b1) begin
            bad++;
            $display("FAIL timeout_rsp: got v=%b rd=%h err=%b to=%b want 1 0 1 1",
                     got, rd, err, to);
        end
    endtask

    task automatic test_timeout_boundary();
        int acc; bit s_ok, h_ok, got, stb; logic [DW-1:0] rd; logic err, to;
        exp_t e;
        // pready on the threshold cycle is a normal completion
        run_xfer(32'h0000_0104, 1'b0, 32'h0, 4'h0, TO - 1, 32'h0BAD_F00D, 1'b0,
                 acc, s_ok, h_ok);
        get_rsp(0, rd, err, to, got, stb);
        e = q.pop_front();
        total++;
        if (!got || acc != e.acc || rd !== e.rdata || err !== 1'b0 || to !== 1'b0) begin
            bad++;
            $display("FAIL to_boundary: got acc=%0d rd=%h err=%b to=%b want %0d %h 0 0",
                     acc, rd, err, to, e.acc, e.rdata);
        end
    endtask

    task automatic test_backpressure();
        int acc; bit s_ok, h_ok, got, stb; logic [DW-1:0] rd; logic err, to;
        exp_t e;
        bit ok;
        run_xfer(32'h0000_0200, 1'b0, 32'h0, 4'h0, 1, 32'h0000_BEEF, 1'b0,
                 acc, s_ok, h_ok);
        e = q.pop_front();
        req_valid_i = 1'b1; req_addr_i = 32'h0000_0300; req_write_i = 1'b1;
        req_wdata_i = 32'h1111_2222; req_strb_i = 4'hC;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err ||
                rsp_timeout_o !== e.to || req_ready_o !== 1'b0 || psel_o !== 1'b0)
                ok = 1'b0;
            tick();
        end
        total++;
        if (!ok || paddr_o !== 32'h0000_0200) begin
            bad++;
            $display("FAIL bp_hold: got hold_ok=%b paddr=%h want 1 00000200", ok, paddr_o);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        total++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got rsp_valid=%b req_ready=%b want 0 1",
                     rsp_valid_o, req_ready_o);
        end
        q.push_back(model(1'b1, 0, 32'h0, 1'b0));
        tick();
        req_valid_i = 1'b0;
        total++;
        if (psel_o !== 1'b1 || penable_o !== 1'b0 || paddr_o !== 32'h0000_0300 ||
            pstrb_o !== 4'hC) begin
            bad++;
            $display("FAIL bp_next_accept: got psel=%b pen=%b addr=%h st=%h want 1 0 00000300 c",
                     psel_o, penable_o, paddr_o, pstrb_o);
        end
        tick();
        pready_i = 1'b1;
        tick();
        pready_i = 1'b0;
        get_rsp(0, rd, err, to, got, stb);
        e = q.pop_front();
        total++;
        if (!got || rd !== e.rdata || err !== e.err || to !== e.to) begin
            bad++;
            $display("FAIL bp_next_rsp: got v=%b rd=%h err=%b to=%b want 1 %h %b %b",
                     got, rd, err, to, e.rdata, e.err, e.to);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        req_valid_i = 1'b1; req_addr_i = 32'h0000_0400; req_write_i = 1'b1;
        req_wdata_i = 32'h7777_8888; req_strb_i = 4'hF;
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        preset_i = 1'b1;
        tick();
        preset_i = 1'b0;
        total++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || rsp_valid_o !== 1'b0 ||
            req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: got psel=%b pen=%b rv=%b rdy=%b want 0 0 0 1",
                     psel_o, penable_o, rsp_valid_o, req_ready_o);
        end
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pready_i = 1'b1;
            tick();
            if (rsp_valid_o !== 1'b0 || psel_o !== 1'b0) ok = 1'b0;
        end
        pready_i = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_reset_drop: got quiet=%b want 1 (no response after reset)", ok);
        end
    endtask

    task automatic test_random();
        int acc; bit s_ok, h_ok, got, stb; logic [DW-1:0] rd; logic err, to;
        exp_t e;
        int errs;
        errs = 0;
        for (int n = 0; n < 300; n++) begin
            run_xfer(32'($urandom) & 32'hFFFF_FFFC, 1'($urandom), 32'($urandom),
                     4'($urandom), $urandom_range(0, 6), 32'($urandom),
                     1'($urandom_range(0, 3) == 0), acc, s_ok, h_ok);
            get_rsp($urandom_range(0, 3), rd, err, to, got, stb);
            e = q.pop_front();
            total++;
            if (!s_ok || !h_ok || !got || !stb || acc != e.acc || rd !== e.rdata ||
                err !== e.err || to !== e.to) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand[%0d]: got s=%b h=%b v=%b st=%b acc=%0d rd=%h err=%b to=%b want 1 1 1 1 %0d %h %b %b",
                             n, s_ok, h_ok, got, stb, acc, rd, err, to,
                             e.acc, e.rdata, e.err, e.to);
            end
        end
        total++;
        if (q.size() != 0 || prot_viol != 0) begin
            bad++;
            $display("FAIL end_state: got queue=%0d protocol_violations=%0d want 0 0",
                     q.size(), prot_viol);
        end
    endtask

    initial begin
        preset_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0;
        req_wdata_i = '0; req_strb_i = '0; rsp_ready_i = 1'b0;
        pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_timeout_boundary();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
